// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Purpose  : Load/store unit between the decode/execute stage and the data
//            memory port. Generates byte enables and lane-replicated store
//            data, stalls the core until memory acknowledges or a bus timeout
//            fires, extracts and sign/zero-extends load data, and flags
//            misaligned or invalid-size accesses.
// Ports    : clk_i, rst_ni            clock, async active-low reset
//            core_req_i/we_i/size_i   access request, direction, size code
//            core_addr_i/wd_i         byte address, store data
//            core_rd_o                extended load data
//            core_stall_o             hold PC / pipeline
//            lsu_misalign_o           bad access, no request issued
//            lsu_fault_o              one-cycle bus-timeout pulse
//            mem_req_o/we_o/be_o      memory request, write enable, enables
//            mem_addr_o/wd_o          address pass-through, store data
//            mem_rd_i/ready_i         memory read word, acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        lsu_misalign_o,
   output logic        lsu_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] c_LDST_B  = 3'd0;
   localparam logic [2:0] c_LDST_H  = 3'd1;
   localparam logic [2:0] c_LDST_W  = 3'd2;
   localparam logic [2:0] c_LDST_BU = 3'd4;
   localparam logic [2:0] c_LDST_HU = 3'd5;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t           r_state, w_next_state;
   logic [CNT_W-1:0] r_cnt, w_next_cnt;

   logic        w_bad, w_go, w_last, w_fault;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_rd;

   assign w_off = core_addr_i[1:0];

   // Alignment / size legality
   always_comb begin
      w_bad = 1'b0;
      case (core_size_i)
         c_LDST_B, c_LDST_BU: w_bad = 1'b0;
         c_LDST_H, c_LDST_HU: w_bad = core_addr_i[0];
         c_LDST_W:            w_bad = (w_off != 2'b00);
         default:             w_bad = 1'b1;
      endcase
   end

   assign w_go   = core_req_i & ~w_bad;
   assign w_last = (r_cnt == c_CNT_LAST);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next state; a dropped request in WAIT is an abort and discards the access
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_fault      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_next_state = S_WAIT;
               w_next_cnt   = '0;
            end
         end
         S_WAIT: begin
            if (!w_go || mem_ready_i) begin
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end else if (w_last) begin
               w_fault      = 1'b1;
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // Byte enables
   always_comb begin
      w_be = 4'b0000;
      case (core_size_i)
         c_LDST_B, c_LDST_BU: w_be = 4'b0001 << w_off;
         c_LDST_H, c_LDST_HU: w_be = 4'b0011 << {core_addr_i[1], 1'b0};
         c_LDST_W:            w_be = 4'b1111;
         default:             w_be = 4'b0000;
      endcase
   end

   // Load lane extraction and extension
   always_comb begin
      w_byte = mem_rd_i[7:0];
      case (w_off)
         2'd0:    w_byte = mem_rd_i[7:0];
         2'd1:    w_byte = mem_rd_i[15:8];
         2'd2:    w_byte = mem_rd_i[23:16];
         default: w_byte = mem_rd_i[31:24];
      endcase
      w_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      w_rd   = '0;
      case (core_size_i)
         c_LDST_B:  w_rd = {{24{w_byte[7]}}, w_byte};
         c_LDST_BU: w_rd = {24'd0, w_byte};
         c_LDST_H:  w_rd = {{16{w_half[15]}}, w_half};
         c_LDST_HU: w_rd = {16'd0, w_half};
         c_LDST_W:  w_rd = mem_rd_i;
         default:   w_rd = '0;
      endcase
   end

   // Store data replicated across lanes so memory only needs the enables
   always_comb begin
      mem_wd_o = core_wd_i;
      case (core_size_i[1:0])
         2'd0:    mem_wd_o = {4{core_wd_i[7:0]}};
         2'd1:    mem_wd_o = {2{core_wd_i[15:0]}};
         default: mem_wd_o = core_wd_i;
      endcase
   end

   // Outputs are held quiet while reset is asserted, independent of the clock
   assign mem_addr_o     = core_addr_i;
   assign mem_req_o      = rst_ni & w_go;
   assign mem_we_o       = rst_ni & w_go & core_we_i;
   assign mem_be_o       = (rst_ni & w_go) ? w_be : 4'b0000;
   assign lsu_misalign_o = rst_ni & core_req_i & w_bad;
   assign lsu_fault_o    = rst_ni & w_fault;
   assign core_stall_o   = rst_ni & w_go &
                           ~((r_state == S_WAIT) & (mem_ready_i | w_last));
   assign core_rd_o      = rst_ni ? w_rd : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Purpose  : Self-checking bench for riscv_lsu: table of single accesses
//            plus directed wait-state, timeout, reset and abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, ready;
   logic [2:0]  size;
   logic [31:0] addr, wd, mrd;
   logic [31:0] rd_o, maddr, mwd;
   logic        stall, mis, fault, mreq, mwe;
   logic [3:0]  be;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   riscv_lsu #(.TIMEOUT(16)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .core_req_i     (req),
      .core_we_i      (we),
      .core_size_i    (size),
      .core_addr_i    (addr),
      .core_wd_i      (wd),
      .core_rd_o      (rd_o),
      .core_stall_o   (stall),
      .lsu_misalign_o (mis),
      .lsu_fault_o    (fault),
      .mem_req_o      (mreq),
      .mem_we_o       (mwe),
      .mem_be_o       (be),
      .mem_addr_o     (maddr),
      .mem_wd_o       (mwd),
      .mem_rd_i       (mrd),
      .mem_ready_i    (ready)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        bad;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic [31:0] erd;
   } vec_t;

   localparam int NV = 15;
   vec_t v[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs are then driven in the low phase
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_lw();
      req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h100; ready = 1'b0;
   endtask

   initial begin
      v[0]  = '{"SW",       1'b1, 3'd2, 32'h100, 32'h11223344, 1'b0, 4'b1111, 32'h11223344, 32'h0};
      v[1]  = '{"SB103",    1'b1, 3'd0, 32'h103, 32'h000000AB, 1'b0, 4'b1000, 32'hABABABAB, 32'h0};
      v[2]  = '{"SH102",    1'b1, 3'd1, 32'h102, 32'h0000BEEF, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
      v[3]  = '{"SB101",    1'b1, 3'd0, 32'h101, 32'hCAFE0012, 1'b0, 4'b0010, 32'h12121212, 32'h0};
      v[4]  = '{"LB103",    1'b0, 3'd0, 32'h103, 32'h0,        1'b0, 4'b1000, 32'h0, 32'hFFFFFF80};
      v[5]  = '{"LBU103",   1'b0, 3'd4, 32'h103, 32'h0,        1'b0, 4'b1000, 32'h0, 32'h00000080};
      v[6]  = '{"LH102",    1'b0, 3'd1, 32'h102, 32'h0,        1'b0, 4'b1100, 32'h0, 32'hFFFF80FF};
      v[7]  = '{"LHU102",   1'b0, 3'd5, 32'h102, 32'h0,        1'b0, 4'b1100, 32'h0, 32'h000080FF};
      v[8]  = '{"LW100",    1'b0, 3'd2, 32'h100, 32'h0,        1'b0, 4'b1111, 32'h0, 32'h80FF7F01};
      v[9]  = '{"LB101",    1'b0, 3'd0, 32'h101, 32'h0,        1'b0, 4'b0010, 32'h0, 32'h0000007F};
      v[10] = '{"LH100",    1'b0, 3'd1, 32'h100, 32'h0,        1'b0, 4'b0011, 32'h0, 32'h00007F01};
      v[11] = '{"LW101bad", 1'b0, 3'd2, 32'h101, 32'h0,        1'b1, 4'b0000, 32'h0, 32'h0};
      v[12] = '{"SH103bad", 1'b1, 3'd1, 32'h103, 32'h1234,     1'b1, 4'b0000, 32'h0, 32'h0};
      v[13] = '{"SZ3bad",   1'b0, 3'd3, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0, 32'h0};
      v[14] = '{"SZ7bad",   1'b1, 3'd7, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0, 32'h0};

      // Reset state with a live request present
      rst_n = 1'b0; req = 1'b1; we = 1'b1; size = 3'd2; addr = 32'h100;
      wd = 32'h11223344; mrd = 32'h80FF7F01; ready = 1'b0;
      @(negedge clk); #1;
      chk("rst_req",   {31'd0, mreq},  32'd0);
      chk("rst_we",    {31'd0, mwe},   32'd0);
      chk("rst_be",    {28'd0, be},    32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_rd",    rd_o,           32'd0);
      step();
      rst_n = 1'b1; req = 1'b0;
      step();

      // Table of single accesses, zero wait states
      for (int i = 0; i < NV; i++) begin
         req = 1'b1; we = v[i].we; size = v[i].size; addr = v[i].addr;
         wd = v[i].wd; mrd = 32'h80FF7F01; ready = 1'b0;
         #1;
         chk({v[i].name, "_mis"},   {31'd0, mis},   {31'd0, v[i].bad});
         chk({v[i].name, "_req"},   {31'd0, mreq},  {31'd0, ~v[i].bad});
         chk({v[i].name, "_we"},    {31'd0, mwe},   {31'd0, ~v[i].bad & v[i].we});
         chk({v[i].name, "_be"},    {28'd0, be},    {28'd0, v[i].be});
         chk({v[i].name, "_stall"}, {31'd0, stall}, {31'd0, ~v[i].bad});
         chk({v[i].name, "_addr"},  maddr,          v[i].addr);
         if (!v[i].bad && v[i].we) chk({v[i].name, "_wd"}, mwd, v[i].ewd);
         step();
         if (!v[i].bad) begin
            ready = 1'b1; #1;
            chk({v[i].name, "_c1stall"}, {31'd0, stall}, 32'd0);
            chk({v[i].name, "_c1fault"}, {31'd0, fault}, 32'd0);
            if (!v[i].we) chk({v[i].name, "_rd"}, rd_o, v[i].erd);
            step();
            req = 1'b0; ready = 1'b0; #1;
            chk({v[i].name, "_idle_stall"}, {31'd0, stall}, 32'd0);
         end else begin
            // A good access with ready present must still stall if FSM is in IDLE
            we = 1'b0; size = 3'd2; addr = 32'h100; ready = 1'b1; #1;
            chk({v[i].name, "_stayidle"}, {31'd0, stall}, 32'd1);
            step();
            #1;
            chk({v[i].name, "_follow_done"}, {31'd0, stall}, 32'd0);
            step();
            req = 1'b0; ready = 1'b0;
         end
         step();
      end

      // Ready after 3 WAIT cycles: stall high for 4 cycles
      start_lw(); #1;
      chk("ws_c0_stall", {31'd0, stall}, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step(); #1;
         chk($sformatf("ws_c%0d_stall", k), {31'd0, stall}, 32'd1);
         chk($sformatf("ws_c%0d_fault", k), {31'd0, fault}, 32'd0);
      end
      step(); ready = 1'b1; #1;
      chk("ws_c4_stall", {31'd0, stall}, 32'd0);
      chk("ws_c4_fault", {31'd0, fault}, 32'd0);
      chk("ws_c4_rd",    rd_o,           32'h80FF7F01);
      step(); req = 1'b0; ready = 1'b0; step();

      // Timeout: no ready ever; fault in WAIT cycle 16
      start_lw(); #1;
      chk("to_c0_stall", {31'd0, stall}, 32'd1);
      for (int k = 1; k <= 16; k++) begin
         step(); #1;
         if (k < 16) begin
            chk($sformatf("to_c%0d_stall", k), {31'd0, stall}, 32'd1);
            chk($sformatf("to_c%0d_fault", k), {31'd0, fault}, 32'd0);
         end else begin
            chk("to_c16_stall", {31'd0, stall}, 32'd0);
            chk("to_c16_fault", {31'd0, fault}, 32'd1);
         end
      end
      step(); #1;
      chk("to_idle_fault", {31'd0, fault}, 32'd0);
      chk("to_idle_stall", {31'd0, stall}, 32'd1);
      req = 1'b0; step(); step();

      // Ready arrives exactly in WAIT cycle 16: completion, no fault
      start_lw();
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 16) ready = 1'b1;
      end
      #1;
      chk("r16_stall", {31'd0, stall}, 32'd0);
      chk("r16_fault", {31'd0, fault}, 32'd0);
      step(); req = 1'b0; ready = 1'b0; #1;
      chk("r16_after_fault", {31'd0, fault}, 32'd0);
      step();

      // Reset asserted in WAIT cycle 2
      start_lw(); step(); step();
      rst_n = 1'b0; #1;
      chk("rw_req",   {31'd0, mreq},  32'd0);
      chk("rw_be",    {28'd0, be},    32'd0);
      chk("rw_stall", {31'd0, stall}, 32'd0);
      chk("rw_fault", {31'd0, fault}, 32'd0);
      chk("rw_rd",    rd_o,           32'd0);
      step();
      rst_n = 1'b1; ready = 1'b1; #1;
      chk("rw_rel_stall", {31'd0, stall}, 32'd1);
      chk("rw_rel_fault", {31'd0, fault}, 32'd0);
      step(); #1;
      chk("rw_done_stall", {31'd0, stall}, 32'd0);
      step(); req = 1'b0; ready = 1'b0; step();

      // Abort: request dropped in WAIT
      start_lw(); step(); step();
      req = 1'b0; #1;
      chk("ab_req",   {31'd0, mreq},  32'd0);
      chk("ab_stall", {31'd0, stall}, 32'd0);
      chk("ab_fault", {31'd0, fault}, 32'd0);
      step();
      req = 1'b1; ready = 1'b1; #1;
      chk("ab_idle_stall", {31'd0, stall}, 32'd1);
      chk("ab_idle_fault", {31'd0, fault}, 32'd0);
      step(); req = 1'b0; ready = 1'b0; step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
